// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the inter-stage pipeline registers.
//   - Payload field offsets so every stage packs/unpacks the opaque payload
//     bus the same way (result, store value / PC, destination, control bits).
//   - Occupancy encodings reported by pipe_stage_skid_reg.
//   - Skid-buffer state encoding, laid out as {skid_valid, main_valid}.
//   - pack_payload(): helper that builds a default-width payload word.
// -----------------------------------------------------------------------------
package pipe_pkg;

   // Payload field widths
   localparam int RES_W   = 32;
   localparam int STV_W   = 32;
   localparam int PC_W    = 32;
   localparam int DEST_W  = 4;
   localparam int CTRL_W  = 3;

   // Payload field offsets. Stages that carry a PC instead of a store value
   // reuse the store-value slot, so PC_LSB aliases STV_LSB.
   localparam int RES_LSB   = 0;
   localparam int STV_LSB   = RES_LSB + RES_W;
   localparam int PC_LSB    = STV_LSB;
   localparam int DEST_LSB  = STV_LSB + STV_W;
   localparam int CTRL_LSB  = DEST_LSB + DEST_W;
   localparam int SPARE_LSB = CTRL_LSB + CTRL_W;

   // Default payload width: 32 res + 32 st_val + 4 dest + 3 ctrl + 1 spare
   localparam int PAYLOAD_W_DEF = SPARE_LSB + 1;

   // Occupancy encodings
   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_TWO   = 2'd2;

   // Skid-buffer state, encoded as {skid_valid, main_valid}
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_FULL1 = 2'b01,
      ST_BAD   = 2'b10,   // skid held without main: never reached
      ST_FULL2 = 2'b11
   } skid_state_e;

   // Build a default-width payload word from its fields; spare bit is zero.
   function automatic logic [PAYLOAD_W_DEF-1:0] pack_payload(
      input logic [RES_W-1:0]  res,
      input logic [STV_W-1:0]  stv,
      input logic [DEST_W-1:0] dest,
      input logic [CTRL_W-1:0] ctrl
   );
      logic [PAYLOAD_W_DEF-1:0] p;
      p                          = '0;
      p[RES_LSB  +: RES_W]       = res;
      p[STV_LSB  +: STV_W]       = stv;
      p[DEST_LSB +: DEST_W]      = dest;
      p[CTRL_LSB +: CTRL_W]      = ctrl;
      return p;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at its all-ones value. Cleared only by reset.
// Ports
//   clk   in   1      rising-edge clock
//   rst   in   1      asynchronous, active-low reset (clears the count)
//   inc   in   1      add one this cycle (ignored once saturated)
//   cnt   out  CNT_W  current count
// -----------------------------------------------------------------------------
module sat_counter
   import pipe_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= sat_inc(cnt);
      end
   end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid_reg
//   Generic inter-stage pipeline register (ID/EX, EX/MEM, MEM/WB) with
//   valid/ready flow control, freeze, flush, and an optional second (skid)
//   entry so that in_ready comes straight from a flop. Also counts cycles of
//   downstream back-pressure for performance debug.
//
// Parameters
//   PAYLOAD_W  width of the opaque payload bus
//   SKID       1: main + skid entries, in_ready from a register
//              0: single entry, in_ready = ~main_valid | out_ready
//   CNT_W      width of the saturating stall counter
//
// Ports
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous, active-low reset
//   freeze     in   1          hold all state; in_ready=0, out_valid=0
//   flush      in   1          synchronous kill of all held entries
//   in_valid   in   1          upstream entry valid
//   in_ready   out  1          block accepts entry this cycle
//   in_data    in   PAYLOAD_W  upstream payload
//   out_valid  out  1          downstream entry valid
//   out_ready  in   1          downstream accepts entry this cycle
//   out_data   out  PAYLOAD_W  downstream payload (main register)
//   occupancy  out  2          entries held (0..2)
//   stall_cnt  out  CNT_W      cycles with out_valid & ~out_ready, saturating
// -----------------------------------------------------------------------------
module pipe_stage_skid_reg
   import pipe_pkg::*;
#(
   parameter int PAYLOAD_W = 72,
   parameter bit SKID      = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 freeze,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_data,
   output logic [1:0]           occupancy,
   output logic [CNT_W-1:0]     stall_cnt
);

   logic                 in_fire;
   logic                 out_fire;
   logic                 flush_eff;
   logic                 stall_inc;

   // Main entry: shared by both modes; the mode-specific logic below only
   // decides its next valid bit, whether it loads, and from where.
   logic                 main_v;
   logic                 main_v_d;
   logic                 main_ld;
   logic [PAYLOAD_W-1:0] main_d;
   logic [PAYLOAD_W-1:0] main_data;

   logic                 skid_v;

   // Freeze masks both handshakes, so no transfer can happen while frozen;
   // the only thing that could still move state is flush, which freeze beats.
   assign out_valid = main_v & ~freeze;
   assign out_data  = main_data;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign flush_eff = flush & ~freeze;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_v    <= 1'b0;
         main_data <= '0;
      end else begin
         main_v <= main_v_d;
         if (main_ld) begin
            main_data <= main_d;
         end
      end
   end

   generate
      if (SKID) begin : g_skid
         logic                 skid_v_r;
         logic                 skid_v_d;
         logic                 skid_ld;
         logic [PAYLOAD_W-1:0] skid_data;
         skid_state_e          state;

         assign state    = skid_state_e'({skid_v_r, main_v});
         // Only the skid flop (and freeze) decide in_ready; nothing from
         // downstream reaches it combinationally.
         assign in_ready = ~skid_v_r & ~freeze;
         assign skid_v   = skid_v_r;

         always_comb begin
            main_v_d = main_v;
            main_ld  = 1'b0;
            main_d   = in_data;
            skid_v_d = skid_v_r;
            skid_ld  = 1'b0;
            if (flush_eff) begin
               // Kill both entries; data registers are left untouched.
               main_v_d = 1'b0;
               skid_v_d = 1'b0;
            end else begin
               case (state)
                  ST_EMPTY: begin
                     if (in_fire) begin
                        main_v_d = 1'b1;
                        main_ld  = 1'b1;
                     end
                  end
                  ST_FULL1: begin
                     if (in_fire && out_fire) begin
                        main_ld = 1'b1;
                     end else if (in_fire) begin
                        // Downstream stalled: park the newer entry in skid.
                        skid_v_d = 1'b1;
                        skid_ld  = 1'b1;
                     end else if (out_fire) begin
                        main_v_d = 1'b0;
                     end
                  end
                  ST_FULL2: begin
                     // in_ready is low here, so only the drain can happen;
                     // skid is always younger than main, so it moves up.
                     if (out_fire) begin
                        main_ld  = 1'b1;
                        main_d   = skid_data;
                        skid_v_d = 1'b0;
                     end
                  end
                  ST_BAD: begin
                     // Unreachable; recover by promoting the skid entry.
                     main_v_d = 1'b1;
                     main_ld  = 1'b1;
                     main_d   = skid_data;
                     skid_v_d = 1'b0;
                  end
               endcase
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               skid_v_r  <= 1'b0;
               skid_data <= '0;
            end else begin
               skid_v_r <= skid_v_d;
               if (skid_ld) begin
                  skid_data <= in_data;
               end
            end
         end

         a_no_orphan_skid: assert property (
            @(posedge clk) disable iff (!rst) !(skid_v_r && !main_v)
         );
      end else begin : g_noskid
         assign skid_v   = 1'b0;
         // Pass-through ready: a full entry can be replaced in the same
         // cycle it is consumed.
         assign in_ready = (~main_v | out_ready) & ~freeze;

         always_comb begin
            main_d  = in_data;
            main_ld = in_fire & ~flush_eff;
            if (flush_eff) begin
               main_v_d = 1'b0;
            end else if (in_fire) begin
               main_v_d = 1'b1;
            end else if (out_fire) begin
               main_v_d = 1'b0;
            end else begin
               main_v_d = main_v;
            end
         end
      end
   endgenerate

   always_comb begin
      case ({skid_v, main_v})
         2'b00:   occupancy = OCC_EMPTY;
         2'b11:   occupancy = OCC_TWO;
         default: occupancy = OCC_ONE;
      endcase
   end

   // out_valid already carries ~freeze, so frozen cycles do not count.
   assign stall_inc = out_valid & ~out_ready;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall_inc),
      .cnt (stall_cnt)
   );

   // A presented entry must not change until it is taken.
   a_out_stable: assert property (
      @(posedge clk) disable iff (!rst)
         (out_valid && !out_ready) |=> $stable(out_data)
   );

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid_reg
//   Directed bench for pipe_stage_skid_reg. Instance A: SKID=1, CNT_W=16.
//   Instance B: SKID=0, CNT_W=4. A scoreboard queue per instance records
//   every accepted entry and is popped on each downstream transfer.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid_reg;
   import pipe_pkg::*;

   localparam int W = PAYLOAD_W_DEF;

   logic          clk = 1'b0;
   logic          rst;
   always #5 clk = ~clk;

   // Instance A
   logic          fz_a, fl_a, iv_a, ir_a, ov_a, or_a;
   logic [W-1:0]  id_a, od_a;
   logic [1:0]    occ_a;
   logic [15:0]   sc_a;
   // Instance B
   logic          fz_b, fl_b, iv_b, ir_b, ov_b, or_b;
   logic [W-1:0]  id_b, od_b;
   logic [1:0]    occ_b;
   logic [3:0]    sc_b;

   int            n_eval = 0;
   int            n_fail = 0;
   logic [W-1:0]  qa[$];
   logic [W-1:0]  qb[$];

   pipe_stage_skid_reg #(.PAYLOAD_W(W), .SKID(1'b1), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .freeze(fz_a), .flush(fl_a),
      .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
      .out_valid(ov_a), .out_ready(or_a), .out_data(od_a),
      .occupancy(occ_a), .stall_cnt(sc_a)
   );

   pipe_stage_skid_reg #(.PAYLOAD_W(W), .SKID(1'b0), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .freeze(fz_b), .flush(fl_b),
      .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
      .out_valid(ov_b), .out_ready(or_b), .out_data(od_b),
      .occupancy(occ_b), .stall_cnt(sc_b)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_eval++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_eval++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   // Called just after a falling edge with inputs already driven. Samples the
   // handshakes before the rising edge, updates the scoreboard, and returns
   // at the next falling edge.
   task automatic tick_a();
      logic [W-1:0] e;
      #2;
      if (ov_a && or_a) begin
         chk1("a_sb_nonempty", qa.size() != 0, 1'b1);
         if (qa.size() != 0) begin
            e = qa.pop_front();
            chk("a_out_data", od_a, e);
         end
      end
      if (iv_a && ir_a) qa.push_back(id_a);
      if (fl_a && !fz_a) qa.delete();
      @(negedge clk);
   endtask

   task automatic tick_b();
      logic [W-1:0] e;
      #2;
      if (ov_b && or_b) begin
         chk1("b_sb_nonempty", qb.size() != 0, 1'b1);
         if (qb.size() != 0) begin
            e = qb.pop_front();
            chk("b_out_data", od_b, e);
         end
      end
      if (iv_b && ir_b) qb.push_back(id_b);
      if (fl_b && !fz_b) qb.delete();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] v;
      rst  = 1'b0;
      fz_a = 1'b0; fl_a = 1'b0; iv_a = 1'b0; or_a = 1'b0; id_a = '0;
      fz_b = 1'b0; fl_b = 1'b0; iv_b = 1'b0; or_b = 1'b0; id_b = '0;

      // Reset state
      @(negedge clk);
      chk1("rst_out_valid_a", ov_a, 1'b0);
      chk ("rst_out_data_a", od_a, '0);
      chk ("rst_occ_a", W'(occ_a), W'(OCC_EMPTY));
      chk ("rst_stall_a", W'(sc_a), '0);
      chk1("rst_out_valid_b", ov_b, 1'b0);
      chk ("rst_occ_b", W'(occ_b), W'(OCC_EMPTY));
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk1("rst_in_ready_a", ir_a, 1'b1);
      chk1("rst_in_ready_b", ir_b, 1'b1);

      // Streaming on A
      or_a = 1'b1;
      iv_a = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         v    = 32'(i);
         id_a = pack_payload(v, ~v, v[3:0], v[2:0]);
         #1;
         chk1("stream_in_ready", ir_a, 1'b1);
         tick_a();
      end
      iv_a = 1'b0;
      tick_a();
      chk("stream_drained", W'(qa.size()), '0);
      chk("stream_stall", W'(sc_a), '0);
      chk("stream_occ", W'(occ_a), W'(OCC_EMPTY));

      // Back-pressure on A
      or_a = 1'b0;
      iv_a = 1'b1;
      id_a = W'(32'h11);
      tick_a();
      id_a = W'(32'h22);
      tick_a();
      chk ("bp_occ", W'(occ_a), W'(OCC_TWO));
      chk1("bp_in_ready", ir_a, 1'b0);
      chk ("bp_out_head", od_a, W'(32'h11));
      id_a = W'(32'h99);
      for (int i = 0; i < 3; i++) tick_a();
      chk("bp_stall", W'(sc_a), W'(4));
      iv_a = 1'b0;
      or_a = 1'b1;
      tick_a();
      tick_a();
      chk("bp_drained", W'(qa.size()), '0);
      chk("bp_occ_end", W'(occ_a), W'(OCC_EMPTY));

      // Flush beats in_fire on A
      or_a = 1'b0;
      iv_a = 1'b1;
      id_a = W'(32'h33);
      tick_a();
      fl_a = 1'b1;
      id_a = W'(32'h44);
      tick_a();
      fl_a = 1'b0;
      iv_a = 1'b0;
      or_a = 1'b1;
      #1;
      chk ("flush_occ", W'(occ_a), W'(OCC_EMPTY));
      chk1("flush_out_valid", ov_a, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick_a();
         chk1("flush_no_44", ov_a, 1'b0);
      end
      chk("flush_stall", W'(sc_a), W'(5));

      // Freeze on A; last frozen cycle also raises flush, which must be dropped
      or_a = 1'b0;
      iv_a = 1'b1;
      id_a = W'(32'h55);
      tick_a();
      fz_a = 1'b1;
      id_a = W'(32'h66);
      for (int i = 0; i < 3; i++) begin
         fl_a = (i == 2);
         #1;
         chk1("frz_in_ready", ir_a, 1'b0);
         chk1("frz_out_valid", ov_a, 1'b0);
         tick_a();
      end
      fl_a = 1'b0;
      chk("frz_stall", W'(sc_a), W'(5));
      chk("frz_occ", W'(occ_a), W'(OCC_ONE));
      fz_a = 1'b0;
      iv_a = 1'b0;
      or_a = 1'b1;
      #1;
      chk1("frz_release_valid", ov_a, 1'b1);
      chk ("frz_release_data", od_a, W'(32'h55));
      tick_a();
      chk("frz_drained", W'(qa.size()), '0);

      // SKID=0 on B: stall saturation and same-cycle replace
      or_b = 1'b0;
      iv_b = 1'b1;
      id_b = W'(32'h77);
      tick_b();
      id_b = W'(32'h88);
      #1;
      chk1("b_full_in_ready", ir_b, 1'b0);
      for (int i = 0; i < 20; i++) tick_b();
      chk("b_stall_sat", W'(sc_b), W'(15));
      chk("b_occ_full", W'(occ_b), W'(OCC_ONE));
      or_b = 1'b1;
      id_b = W'(32'h99);
      #1;
      chk1("b_passthru_ready", ir_b, 1'b1);
      tick_b();
      chk("b_replace_occ", W'(occ_b), W'(OCC_ONE));
      chk("b_replace_data", od_b, W'(32'h99));
      iv_b = 1'b0;
      tick_b();
      chk("b_occ_end", W'(occ_b), W'(OCC_EMPTY));
      chk("b_drained", W'(qb.size()), '0);
      chk("b_stall_hold", W'(sc_b), W'(15));

      // Asynchronous reset mid-stream on A (FULL2 with 0xA / 0xB)
      or_a = 1'b0;
      iv_a = 1'b1;
      id_a = W'(32'hA);
      tick_a();
      id_a = W'(32'hB);
      tick_a();
      iv_a = 1'b0;
      chk("ar_occ_pre", W'(occ_a), W'(OCC_TWO));
      rst = 1'b0;
      #1;
      chk1("ar_out_valid", ov_a, 1'b0);
      chk ("ar_out_data", od_a, '0);
      chk ("ar_occ", W'(occ_a), W'(OCC_EMPTY));
      chk ("ar_stall", W'(sc_a), '0);
      qa.delete();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk1("ar_in_ready", ir_a, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
      $finish;
   end

endmodule
